// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Purpose  : PS/2 keyboard receiver that deframes 11-bit frames into a FWFT byte FIFO.
//            Optional macro PS2_GLITCH_FILTER_EN adds an integrator on ps2_clk.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 32000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers, preset to the idle-high bus level
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    logic clk_level;

`ifdef PS2_GLITCH_FILTER_EN
    logic [3:0] integ_q, integ_d;
    logic       filt_q, filt_d;

    // Level only changes once the integrator saturates at either rail.
    always_comb begin
        integ_d = integ_q;
        filt_d  = filt_q;
        if (clk_s && (integ_q != 4'd15)) begin
            integ_d = integ_q + 4'd1;
        end else if (!clk_s && (integ_q != 4'd0)) begin
            integ_d = integ_q - 4'd1;
        end
        if (integ_q == 4'd15) begin
            filt_d = 1'b1;
        end else if (integ_q == 4'd0) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            integ_q <= 4'd15;
            filt_q  <= 1'b1;
        end else begin
            integ_q <= integ_d;
            filt_q  <= filt_d;
        end
    end

    assign clk_level = filt_q;
`else
    assign clk_level = clk_s;
`endif

    // ------------------------------------------------------------------
    // Falling-edge detect
    // ------------------------------------------------------------------
    logic clk_prev_q;
    logic fall;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_level;
        end
    end

    assign fall = clk_prev_q & ~clk_level;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             push;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bit_cnt_d = 3'd0;
                shift_d   = 8'h00;
                tmo_d     = '0;
                if (fall && !data_s) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = data_s;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (^{shift_q, parity_q} == 1'b0) begin
                        parity_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fall in the same cycle as expiry keeps the frame alive.
        if (state_q != S_IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // First-word fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic             full;
    logic             do_push;

    assign pop     = rd_en && (count_q != '0);
    assign full    = (count_q == CNT_FULL);
    assign do_push = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push && full && !pop;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked until an entry is valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_keyboard_rx
// Purpose  : Directed, table-driven bench for ps2_keyboard_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int T_TMO = 2000;
    localparam int HALF  = 40;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_keyboard_rx #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(T_TMO),
        .FIFO_DEPTH    (4)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int pe_tot = 0, fe_tot = 0, ov_tot = 0, vr_tot = 0;
    logic v_prev = 1'b0;
    int last_fall = 0;

    // Pulse counters accumulate high cycles, so a wide pulse counts more than once.
    always @(negedge CLK) begin
        if (parity_err === 1'b1) pe_tot = pe_tot + 1;
        if (frame_err === 1'b1)  fe_tot = fe_tot + 1;
        if (overflow === 1'b1)   ov_tot = ov_tot + 1;
        if (rx_valid === 1'b1 && v_prev !== 1'b1) vr_tot = vr_tot + 1;
        v_prev = rx_valid;
    end

    typedef struct {
        logic [7:0] d;
        bit         bad_par;
        bit         bad_stop;
        int         exp_pe;
        int         exp_fe;
        int         exp_rise;
    } vec_t;

    vec_t tbl[7];

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(bad_par ? ^d : ~^d);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    // Good frame with rd_en raised for exactly the cycle the stop-bit fall is detected.
    task automatic send_frame_pop(input logic [7:0] d);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(HALF - 3);
        ps2_clk = 1'b1;
        tick(HALF);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe0, fe0, ov0, vr0, delta;

        tbl[0] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1};
        tbl[1] = '{8'h1C, 1'b1, 1'b0, 1, 0, 0};
        tbl[2] = '{8'hF0, 1'b0, 1'b1, 0, 1, 0};
        tbl[3] = '{8'hF0, 1'b1, 1'b1, 0, 1, 0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 0, 0, 1};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 0, 0, 1};
        tbl[6] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0};

        // Reset state
        tick(3);
        check("rst_rx_valid", {31'd0, rx_valid}, 0);
        check("rst_rx_data", {24'd0, rx_data}, 0);
        check("rst_parity_err", {31'd0, parity_err}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        reset = 1'b1;
        tick(5);

        // Table-driven single frames
        for (int v = 0; v < 7; v++) begin
            pe0 = pe_tot; fe0 = fe_tot; vr0 = vr_tot;
            send_frame(tbl[v].d, tbl[v].bad_par, tbl[v].bad_stop);
            check($sformatf("v%0d_parity_err", v), pe_tot - pe0, tbl[v].exp_pe);
            check($sformatf("v%0d_frame_err", v), fe_tot - fe0, tbl[v].exp_fe);
            check($sformatf("v%0d_valid_rise", v), vr_tot - vr0, tbl[v].exp_rise);
            check($sformatf("v%0d_rx_valid", v), {31'd0, rx_valid}, tbl[v].exp_rise);
            if (tbl[v].exp_rise != 0) begin
                check($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, tbl[v].d});
                pop1();
                check($sformatf("v%0d_after_pop", v), {31'd0, rx_valid}, 0);
            end
        end

        // Timeout after start + 5 data bits, then a good frame
        fe0 = fe_tot; pe0 = pe_tot;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i >= 4);
        ps2_data = 1'b1;
        while (fe_tot == fe0 && (cyc - last_fall) < T_TMO + 200) tick(1);
        delta = cyc - last_fall;
        check("tmo_frame_err", fe_tot - fe0, 1);
        n_vec++;
        if (delta < T_TMO || delta > T_TMO + 24) begin
            n_err++;
            $display("FAIL tmo_delay: got %0d cycles, expected %0d..%0d", delta, T_TMO, T_TMO + 24);
        end
        check("tmo_no_parity_err", pe_tot - pe0, 0);
        check("tmo_rx_valid", {31'd0, rx_valid}, 0);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("post_tmo_rx_valid", {31'd0, rx_valid}, 1);
        check("post_tmo_rx_data", {24'd0, rx_data}, 32'hF0);
        pop1();

        // Overflow on the 5th byte with no reads
        ov0 = ov_tot; vr0 = vr_tot;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("ovf_pulse", ov_tot - ov0, 1);
        check("ovf_valid_rise", vr_tot - vr0, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_pop%0d", i), {24'd0, rx_data}, i);
            pop1();
        end
        check("ovf_drained", {31'd0, rx_valid}, 0);

        // rd_en held through the whole 5th frame
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
        ov0 = ov_tot;
        rd_en = 1'b1;
        send_frame(8'h05, 1'b0, 1'b0);
        rd_en = 1'b0;
        check("held_no_ovf", ov_tot - ov0, 0);
        check("held_drained", {31'd0, rx_valid}, 0);

        // Push and pop in the same cycle while full
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
        ov0 = ov_tot;
        send_frame_pop(8'h05);
        check("pp_no_ovf", ov_tot - ov0, 0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("pp_pop%0d", i), {24'd0, rx_data}, i);
            pop1();
        end
        check("pp_drained", {31'd0, rx_valid}, 0);

        // Asynchronous reset mid-frame with a byte already queued
        send_frame(8'h33, 1'b0, 1'b0);
        check("pre_rst_valid", {31'd0, rx_valid}, 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 0);
        check("mid_rst_rx_data", {24'd0, rx_data}, 0);
        check("mid_rst_errs", {29'd0, parity_err, frame_err, overflow}, 0);
        tick(3);
        reset = 1'b1;
        tick(5);
        vr0 = vr_tot; pe0 = pe_tot; fe0 = fe_tot;
        send_frame(8'h5A, 1'b0, 1'b0);
        check("post_rst_rise", vr_tot - vr0, 1);
        check("post_rst_data", {24'd0, rx_data}, 32'h5A);
        check("post_rst_errs", (pe_tot - pe0) + (fe_tot - fe0), 0);
        pop1();

        // Three-cycle glitch on ps2_clk while idle with data low
        fe0 = fe_tot;
        ps2_data = 1'b0;
        tick(2);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(2);
        ps2_data = 1'b1;
        tick(T_TMO + 60);
`ifdef PS2_GLITCH_FILTER_EN
        check("glitch_frame_err", fe_tot - fe0, 0);
`else
        check("glitch_frame_err", fe_tot - fe0, 1);
`endif
        check("glitch_rx_valid", {31'd0, rx_valid}, 0);
        vr0 = vr_tot;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("post_glitch_rise", vr_tot - vr0, 1);
        check("post_glitch_data", {24'd0, rx_data}, 32'h1C);
        pop1();
        check("post_glitch_drained", {31'd0, rx_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver for the keyboard input pins (keyboard data and keyboard clock) on the 16 MHz board clock domain.
- Synchronises the asynchronous PS/2 lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and buffers good scan-code bytes in a small first-word-fall-through FIFO.
- Consumer is the CPU's keyboard I/O register. Decode (make/break/E0) is done downstream.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data; legal range 2..3.
- TIMEOUT_CYCLES, 32000, CLK cycles allowed between falling ps2_clk edges inside a frame (2 ms at 16 MHz).
- FIFO_DEPTH, 4, byte entries; power of two, 2..16.

Ports:
- CLK  input  1  board clock, 16 MHz.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw keyboard clock pin, asynchronous.
- ps2_data  input  1  raw keyboard data pin, asynchronous.
- rd_en  input  1  pop request; honoured only while rx_valid=1.
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- parity_err  output  1  one-cycle pulse: frame dropped on parity mismatch.
- frame_err  output  1  one-cycle pulse: frame dropped on bad stop bit or timeout.
- overflow  output  1  one-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; bit counter, shift register, timeout counter and FIFO pointers clear.
  - Synchroniser flops preset to 1 (bus idle).
  - Outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overflow=0.
- Deassertion is assumed synchronous to CLK at board level.
- Edge detect:
  - fall = registered synced ps2_clk is 1 and current synced ps2_clk is 0.
  - ps2_data is sampled from its synced copy in the cycle fall=1.
- FSM states:
  - IDLE: on fall with data=0, go to DATA with bit count 0. On fall with data=1 (bad start bit), stay in IDLE with no error pulse.
  - DATA: on each fall, shift data into bit[count], LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame and return to IDLE.
- Frame evaluation:
  - Stop=0: frame_err pulse, byte dropped.
  - Stop=1 and XOR(data,parity)=0: parity_err pulse, byte dropped.
  - Otherwise the byte is good and is pushed on the cycle after the stop-bit fall. rx_valid rises in that same cycle if the FIFO was empty.
  - If both stop and parity are bad, only frame_err pulses.
- Timeout:
  - In any state except IDLE, the counter increments every cycle and clears on fall.
  - When the count reaches TIMEOUT_CYCLES: go to IDLE, frame_err pulse, partial byte discarded.
  - If the timeout and a fall coincide, the fall wins.
- FIFO (first-word fall-through):
  - rx_data shows the head entry combinationally from the registered FIFO.
  - rd_en with rx_valid=1 pops at the clock edge. rd_en while empty is ignored.
  - Push while full and no pop: byte dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: not possible, because a pop needs rx_valid=1.
  - Pointers wrap modulo FIFO_DEPTH; a count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Error pulses are registered, exactly one cycle wide, and never coincide with a push of the same frame.

Optional Feature:
- Macro: PS2_GLITCH_FILTER_EN.
- When defined: the synced ps2_clk passes through a 4-bit saturating integrator that must reach 15 (rising) or 0 (falling) before the filtered level changes. Edge detect uses the filtered level. This adds 15 cycles of latency; pulses shorter than 15 cycles are rejected.
- When undefined: no filter, edge detect uses the raw synced level, and a one-cycle glitch is taken as a valid edge.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz -> exactly one rx_valid rise, rx_data=0x1C, no error pulses; rd_en pulse -> rx_valid=0.
- Frame 0x1C with parity=1 -> one parity_err pulse, rx_valid stays 0. Frame 0xF0 with stop=0 -> one frame_err pulse.
- Start bit plus 5 data bits, then idle -> frame_err pulses TIMEOUT_CYCLES cycles after the 5th fall. A following 0xF0 frame is received correctly.
- Five good frames 0x01..0x05 with no rd_en -> overflow pulses on the 5th; pops return 0x01..0x04, then rx_valid=0. Repeat with rd_en held for the whole 5th frame -> no overflow.
- Reset asserted after 4 data bits -> all outputs 0 immediately. After release, a new 0x5A frame is received correctly.
- With PS2_GLITCH_FILTER_EN, a 3-cycle low pulse on ps2_clk while IDLE (data=0) -> FSM stays IDLE, and a following 0x1C frame is received correctly. Without the macro, the same pulse begins a frame that later ends in frame_err by timeout.
